// File: rtl/wb_reram_pkg.sv
// Shared types and constants for the Wishbone-to-ReRAM bridge.
package wb_reram_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ACK,
        S_ABORT
    } state_t;

    localparam logic [3:0] STATUS_OFS = 4'h0;
    localparam logic [3:0] DATA_OFS   = 4'hC;

    localparam int unsigned TO = 0;
    localparam int unsigned SE = 1;

endpackage

// File: rtl/wb_reram_addr_dec.sv
// Combinational window decode: hit, channel index and offset/byte-select validity.
module wb_reram_addr_dec
    import wb_reram_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            i_stb,
    input  logic            i_cyc,
    input  logic [31:0]     i_adr,
    input  logic [3:0]      i_sel,
    output logic            o_hit,
    output logic [CH_W-1:0] o_ch,
    output logic            o_valid,
    output logic            o_is_data
);
    localparam int unsigned AW = 4 + $clog2(N_CH);

    logic [3:0] w_ofs;

    // Base is aligned to the window size, so an upper-bit match is the range check.
    assign o_hit = i_stb & i_cyc & (i_adr[31:AW] == BASE_ADDR[31:AW]);
    assign w_ofs = i_adr[3:0];

    generate
        if (N_CH > 1) begin : g_multi
            assign o_ch = i_adr[4 +: CH_W];
        end else begin : g_single
            assign o_ch = '0;
        end
    endgenerate

    assign o_is_data = (w_ofs == DATA_OFS);
    assign o_valid   = ((w_ofs == STATUS_OFS) || (w_ofs == DATA_OFS)) && (i_sel == 4'hF);

endmodule

// File: rtl/wb_reram_bridge.sv
// Wishbone slave bridging to N_CH ReRAM cores with per-channel sticky status.
// Optional watchdog enabled by defining WB_RERAM_BRIDGE_WDOG_EN.
module wb_reram_bridge
    import wb_reram_pkg::*;
#(
    parameter int unsigned N_CH      = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    input  logic [3:0]         wbs_sel_i,
    output logic [31:0]        wbs_dat_o,
    output logic               wbs_ack_o,
    output logic               wbs_err_o,
    output logic [N_CH-1:0]    core_en_o,
    output logic               core_r_wb_o,
    output logic [31:0]        core_di_o,
    output logic [31:0]        core_ad_o,
    output logic [3:0]         core_sel_o,
    input  logic [N_CH*32-1:0] core_do_i,
    input  logic [N_CH-1:0]    core_ack_i
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    generate
        if (N_CH < 1 || N_CH > 16 || (N_CH & (N_CH - 1)) != 0) begin : g_bad_nch
            $error("N_CH must be a power of two in 1..16");
        end
        if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
            $error("TIMEOUT must be in 1..255");
        end
    endgenerate

    state_t          r_state, w_next;
    logic            w_hit, w_valid, w_is_data;
    logic [CH_W-1:0] w_dec_ch;
    logic [CH_W-1:0] r_ch;
    logic            r_rwb, r_rsp_err;
    logic [31:0]     r_adr, r_di, r_dat;
    logic [3:0]      r_sel;
    logic [N_CH-1:0] r_en, r_to, r_se, w_oh;
    logic [31:0]     w_rdat;
    logic            w_sel_ack, w_wd_hit;

    wb_reram_addr_dec #(
        .N_CH      (N_CH),
        .BASE_ADDR (BASE_ADDR),
        .CH_W      (CH_W)
    ) u_dec (
        .i_stb     (wbs_stb_i),
        .i_cyc     (wbs_cyc_i),
        .i_adr     (wbs_adr_i),
        .i_sel     (wbs_sel_i),
        .o_hit     (w_hit),
        .o_ch      (w_dec_ch),
        .o_valid   (w_valid),
        .o_is_data (w_is_data)
    );

    always_comb begin
        w_rdat    = '0;
        w_sel_ack = 1'b0;
        w_oh      = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            if (r_ch == CH_W'(c)) begin
                w_rdat    = core_do_i[c*32 +: 32];
                w_sel_ack = core_ack_i[c];
                w_oh[c]   = 1'b1;
            end
        end
    end

`ifdef WB_RERAM_BRIDGE_WDOG_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_wd;

    // Keeps counting across WAIT->ABORT so an abandoned core is bounded in total.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || !(r_state == S_WAIT || r_state == S_ABORT)) begin
            r_wd <= '0;
        end else begin
            r_wd <= r_wd + 8'd1;
        end
    end
    assign w_wd_hit = (r_wd == WD_LAST);
`else
    assign w_wd_hit = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_hit) w_next = (w_valid && w_is_data) ? S_REQ : S_ACK;
            S_REQ:   w_next = S_WAIT;
            S_WAIT: begin
                if (w_sel_ack)       w_next = S_ACK;
                else if (!wbs_cyc_i) w_next = S_ABORT;
                else if (w_wd_hit)   w_next = S_ACK;
            end
            S_ACK:   w_next = S_IDLE;
            S_ABORT: if (w_sel_ack || w_wd_hit) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ch      <= '0;
            r_rwb     <= 1'b0;
            r_rsp_err <= 1'b0;
            r_adr     <= '0;
            r_di      <= '0;
            r_dat     <= '0;
            r_sel     <= '0;
            r_en      <= '0;
            r_to      <= '0;
            r_se      <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_hit) begin
                    r_ch <= w_dec_ch;
                    if (w_valid && w_is_data) begin
                        r_rwb <= ~wbs_we_i;
                        r_adr <= wbs_adr_i;
                        r_di  <= wbs_dat_i;
                        r_sel <= wbs_sel_i;
                    end else if (w_valid) begin
                        r_rsp_err <= 1'b0;
                        if (wbs_we_i) begin
                            r_dat <= '0;
                            if (wbs_dat_i[TO]) r_to[w_dec_ch] <= 1'b0;
                            if (wbs_dat_i[SE]) r_se[w_dec_ch] <= 1'b0;
                        end else begin
                            r_dat <= {30'd0, r_se[w_dec_ch], r_to[w_dec_ch]};
                        end
                    end else begin
                        r_rsp_err      <= 1'b1;
                        r_dat          <= '0;
                        r_se[w_dec_ch] <= 1'b1;
                    end
                end
                S_REQ: r_en <= w_oh;
                S_WAIT: begin
                    if (w_sel_ack) begin
                        r_en      <= '0;
                        r_rsp_err <= 1'b0;
                        r_dat     <= r_rwb ? w_rdat : '0;
                    end else if (!wbs_cyc_i) begin
                        r_en <= '0;
                    end else if (w_wd_hit) begin
                        r_en       <= '0;
                        r_rsp_err  <= 1'b1;
                        r_dat      <= '0;
                        r_to[r_ch] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wbs_dat_o   = r_dat;
    assign wbs_ack_o   = (r_state == S_ACK) & ~r_rsp_err;
    assign wbs_err_o   = (r_state == S_ACK) &  r_rsp_err;
    assign core_en_o   = r_en;
    assign core_r_wb_o = r_rwb;
    assign core_di_o   = r_di;
    assign core_ad_o   = r_adr;
    assign core_sel_o  = r_sel;

endmodule

// File: tb/tb_wb_reram_bridge.sv
// Randomized self-checking bench for wb_reram_bridge against a transaction-level model.
module tb_wb_reram_bridge;
    localparam int unsigned NCH  = 4;
    localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef WB_RERAM_BRIDGE_WDOG_EN
    localparam int unsigned TMO = 16;
`else
    localparam int unsigned TMO = 255;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              stb, cyc, we;
    logic [31:0]       adr, dat_i, dat_o;
    logic [3:0]        sel;
    logic              ack, err;
    logic [NCH-1:0]    en;
    logic              rwb;
    logic [31:0]       di, ad;
    logic [3:0]        csel;
    logic [NCH*32-1:0] cdo;
    logic [NCH-1:0]    cack;

    wb_reram_bridge #(
        .N_CH      (NCH),
        .BASE_ADDR (BASE),
        .TIMEOUT   (TMO)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_stb_i   (stb),
        .wbs_cyc_i   (cyc),
        .wbs_we_i    (we),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat_i),
        .wbs_sel_i   (sel),
        .wbs_dat_o   (dat_o),
        .wbs_ack_o   (ack),
        .wbs_err_o   (err),
        .core_en_o   (en),
        .core_r_wb_o (rwb),
        .core_di_o   (di),
        .core_ad_o   (ad),
        .core_sel_o  (csel),
        .core_do_i   (cdo),
        .core_ack_i  (cack)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: sticky flags per channel.
    bit m_to [NCH];
    bit m_se [NCH];

    // Observations of the last transaction.
    int             t_lat, t_encnt, t_bad;
    logic           t_ack, t_err;
    logic [31:0]    t_dat;
    logic [NCH-1:0] t_enor, t_en_rsp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic noise();
        for (int c = 0; c < NCH; c++) cdo[c*32 +: 32] = $urandom;
    endtask

    // Issue one bus request and emulate the addressed core; dly < 0 means the core never acks.
    task automatic xact(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                        input int dly, input logic [31:0] cdat, input int wch, input int budget);
        int n;
        int ch;
        bit done;
        ch = int'(a[5:4]);
        n = 0; done = 0;
        t_lat = -1; t_encnt = 0; t_bad = 0; t_ack = 0; t_err = 0; t_dat = '0;
        t_enor = '0; t_en_rsp = '0;
        @(negedge clk);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
            cack = '0;
            noise();
            if (ack || err) begin
                t_ack = ack; t_err = err; t_dat = dat_o; t_lat = n; t_en_rsp = en;
                done = 1;
                stb = 1'b0; cyc = 1'b0;
            end else if (en != '0) begin
                t_encnt++;
                t_enor |= en;
                if ($countones(en) != 1) t_bad++;
                if (ad !== a || rwb !== ~w || csel !== s || (w && di !== d)) t_bad++;
                if (dly >= 0 && t_encnt == dly + 1) begin
                    cack[ch] = 1'b1;
                    cdo[ch*32 +: 32] = cdat;
                end else if (wch >= 0 && t_encnt == 1) begin
                    cack[wch] = 1'b1;
                end
            end
        end
        stb = 1'b0; cyc = 1'b0; cack = '0;
    endtask

    task automatic expect_rsp(input string tag, input bit e_ack, input bit e_err, input logic [31:0] e_dat,
                              input int e_lat, input logic [NCH-1:0] e_en, input int e_encnt);
        check({tag, ".ack"}, 32'(t_ack), 32'(e_ack));
        check({tag, ".err"}, 32'(t_err), 32'(e_err));
        check({tag, ".dat"}, t_dat, e_dat);
        check({tag, ".lat"}, 32'(t_lat), 32'(e_lat));
        check({tag, ".en"}, 32'(t_enor), 32'(e_en));
        check({tag, ".encnt"}, 32'(t_encnt), 32'(e_encnt));
        check({tag, ".en_at_rsp"}, 32'(t_en_rsp), 32'd0);
        check({tag, ".latched"}, 32'(t_bad), 32'd0);
    endtask

    function automatic logic [31:0] cadr(input int ch, input logic [3:0] ofs);
        return BASE + 32'(ch * 16) + 32'(ofs);
    endfunction

    task automatic do_data(input string tag, input int ch, input logic w, input logic [31:0] d,
                           input int dly, input int wch);
        logic [31:0] cdat;
        logic [NCH-1:0] oh;
        cdat = $urandom;
        oh = '0;
        oh[ch] = 1'b1;
        xact(cadr(ch, 4'hC), w, d, 4'hF, dly, cdat, wch, 400);
        if (dly >= 0) begin
            expect_rsp(tag, 1, 0, w ? 32'd0 : cdat, 3 + dly, oh, dly + 1);
        end else begin
            m_to[ch] = 1;
            expect_rsp(tag, 0, 1, 32'd0, int'(TMO) + 2, oh, int'(TMO));
        end
    endtask

    task automatic do_status(input string tag, input int ch, input logic w, input logic [31:0] d);
        logic [31:0] exp;
        exp = w ? 32'd0 : {30'd0, m_se[ch], m_to[ch]};
        xact(cadr(ch, 4'h0), w, d, 4'hF, 0, 32'd0, -1, 40);
        expect_rsp(tag, 1, 0, exp, 1, '0, 0);
        if (w) begin
            if (d[0]) m_to[ch] = 0;
            if (d[1]) m_se[ch] = 0;
        end
    endtask

    task automatic do_bad(input string tag, input int ch, input logic [3:0] ofs, input logic [3:0] s, input logic w);
        xact(cadr(ch, ofs), w, $urandom, s, 0, 32'd0, -1, 40);
        expect_rsp(tag, 0, 1, 32'd0, 1, '0, 0);
        m_se[ch] = 1;
    endtask

    task automatic do_miss(input string tag, input logic [31:0] a);
        xact(a, $urandom_range(0, 1) == 1, $urandom, 4'hF, 0, 32'd0, -1, 6);
        check({tag, ".ack"}, 32'(t_ack), 32'd0);
        check({tag, ".err"}, 32'(t_err), 32'd0);
        check({tag, ".en"}, 32'(t_enor), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "global timeout");
    end

    initial begin
        int ch, r, dly, acc;
        rst = 1'b1; stb = 0; cyc = 0; we = 0; adr = '0; dat_i = '0; sel = '0; cack = '0; cdo = '0;
        for (int c = 0; c < NCH; c++) begin m_to[c] = 0; m_se[c] = 0; end
        repeat (3) @(posedge clk);
        #1;
        check("rst.ack", 32'(ack), 32'd0);
        check("rst.err", 32'(err), 32'd0);
        check("rst.dat", dat_o, 32'd0);
        check("rst.en", 32'(en), 32'd0);
        check("rst.rwb", 32'(rwb), 32'd0);
        check("rst.ad", ad, 32'd0);
        check("rst.di", di, 32'd0);
        check("rst.sel", 32'(csel), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases from the plan.
        xact(32'h3000_002C, 1'b0, 32'd0, 4'hF, 5, 32'hDEAD_BEEF, -1, 400);
        expect_rsp("rd_ch2", 1, 0, 32'hDEAD_BEEF, 8, 4'b0100, 6);
        do_data("wr_ch0", 0, 1'b1, 32'h1234_5678, 2, -1);
        do_status("st0_rd", 0, 1'b0, 32'd0);
        do_bad("sel_err", 1, 4'hC, 4'b0011, 1'b0);
        do_status("st1_rd", 1, 1'b0, 32'd0);
        do_status("st1_w1c", 1, 1'b1, 32'h2);
        do_status("st1_rd2", 1, 1'b0, 32'd0);
        do_miss("miss40", 32'h3000_0040);
        do_miss("miss_lo", 32'h2FFF_FFFC);
        do_data("wrong_ch", 2, 1'b0, 32'd0, 3, 1);

        // Master abandons a read on ch3 while the core is busy.
        @(negedge clk);
        stb = 1; cyc = 1; we = 0; adr = 32'h3000_003C; dat_i = '0; sel = 4'hF;
        acc = 0;
        while (en == '0 && acc < 10) begin @(negedge clk); acc++; end
        check("abort.en", 32'(en), 32'(4'b1000));
        stb = 0; cyc = 0;
        acc = 0;
        repeat (4) begin @(negedge clk); acc += int'(ack) + int'(err) + ((en != '0) ? 1 : 0); end
        check("abort.quiet", 32'(acc), 32'd0);
        cack[3] = 1'b1;
        @(negedge clk);
        cack = '0;
        acc = 0;
        repeat (3) begin @(negedge clk); acc += int'(ack) + int'(err) + ((en != '0) ? 1 : 0); end
        check("abort.late_ack", 32'(acc), 32'd0);
        do_data("after_abort", 3, 1'b0, 32'd0, 1, -1);

`ifdef WB_RERAM_BRIDGE_WDOG_EN
        do_data("wdog", 1, 1'b0, 32'd0, -1, -1);
        do_status("wdog_st", 1, 1'b0, 32'd0);
        do_status("wdog_w1c", 1, 1'b1, 32'h1);
        do_status("wdog_st2", 1, 1'b0, 32'd0);
`endif

        for (int i = 0; i < 80; i++) begin
            ch = $urandom_range(0, NCH - 1);
            r  = $urandom_range(0, 9);
            if (r < 4) begin
                dly = $urandom_range(0, 6);
`ifdef WB_RERAM_BRIDGE_WDOG_EN
                if ($urandom_range(0, 7) == 0) dly = -1;
`endif
                do_data("rnd_data", ch, $urandom_range(0, 1) == 1, $urandom, dly,
                        (dly >= 1 && $urandom_range(0, 1) == 1) ? int'((ch + 1) % NCH) : -1);
            end else if (r < 6) begin
                do_status("rnd_st", ch, $urandom_range(0, 1) == 1, $urandom);
            end else if (r < 8) begin
                do_bad("rnd_ofs", ch, 4'($urandom_range(1, 11)), 4'hF, $urandom_range(0, 1) == 1);
            end else if (r == 8) begin
                do_bad("rnd_sel", ch, ($urandom_range(0, 1) == 1) ? 4'hC : 4'h0,
                       4'($urandom_range(0, 14)), $urandom_range(0, 1) == 1);
            end else begin
                do_miss("rnd_miss", BASE + 32'(NCH * 16) + 32'($urandom_range(0, 4095)));
            end
        end

        for (int c = 0; c < NCH; c++) do_status("final_st", c, 1'b0, 32'd0);

        // Reset in the middle of a core access.
        @(negedge clk);
        stb = 1; cyc = 1; we = 0; adr = 32'h3000_001C; sel = 4'hF;
        acc = 0;
        while (en == '0 && acc < 10) begin @(negedge clk); acc++; end
        check("mrst.en_before", 32'(en), 32'(4'b0010));
        rst = 1; stb = 0; cyc = 0;
        @(negedge clk);
        check("mrst.en", 32'(en), 32'd0);
        check("mrst.ack", 32'(ack) + 32'(err), 32'd0);
        rst = 0;
        for (int c = 0; c < NCH; c++) begin m_to[c] = 0; m_se[c] = 0; end
        for (int c = 0; c < NCH; c++) do_status("post_rst_st", c, 1'b0, 32'd0);
        do_data("post_rst_rd", 0, 1'b0, 32'd0, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
